// File: rtl/ntt_ctrl_pkg.sv
// Shared types and helpers for the 16-point iterative NTT controller:
// FSM state encoding, 4-bit bit reversal and the twiddle power table.
package ntt_ctrl_pkg;

  localparam int unsigned NTT_N      = 16;
  localparam int unsigned TW_ENTRIES = NTT_N / 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_UNLOAD
  } state_e;

  typedef logic [TW_ENTRIES-1:0][31:0] tw_table_t;

  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  // Entry k holds root^k mod modulus; evaluated at elaboration time.
  function automatic tw_table_t twiddle_table(input int unsigned root,
                                              input int unsigned modulus);
    tw_table_t       t;
    longint unsigned acc;
    acc = 64'd1;
    for (int unsigned k = 0; k < TW_ENTRIES; k++) begin
      t[k] = 32'(acc % modulus);
      acc  = (acc * root) % modulus;
    end
    return t;
  endfunction

endpackage

// File: rtl/ntt_iter_ctrl_bfly.sv
// Cooley-Tukey modular butterfly: out_sum = u + w*v, out_diff = u - w*v, both mod MODULUS.
// Purely combinational; operands are assumed already reduced below MODULUS.
module ntt_butterfly #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MODULUS    = 17
) (
  input  logic [DATA_WIDTH-1:0] u,
  input  logic [DATA_WIDTH-1:0] v,
  input  logic [DATA_WIDTH-1:0] twiddle,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic [DATA_WIDTH-1:0] out_diff
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic [PW-1:0] prod;
  logic [PW-1:0] prod_mod;

  assign prod     = PW'(twiddle) * PW'(v);
  assign prod_mod = prod % PW'(MODULUS);

  // Adding MODULUS before subtracting keeps the difference non-negative.
  assign out_sum  = DATA_WIDTH'((PW'(u) + prod_mod) % PW'(MODULUS));
  assign out_diff = DATA_WIDTH'((PW'(u) + PW'(MODULUS) - prod_mod) % PW'(MODULUS));

endmodule

// File: rtl/ntt_iter_ctrl.sv
// 16-point iterative NTT controller: serial load, 32 in-place butterflies, serial unload.
// Define NTT_CTRL_BITREV_EN to bit-reverse load addresses so input is in natural order.
module ntt_iter_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int unsigned N          = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MODULUS    = 17,
  parameter int unsigned ROOT       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam tw_table_t TW = twiddle_table(ROOT, MODULUS);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [4:0]      comp_q, comp_d;
  logic [DATA_WIDTH-1:0] bank_q [N];

  logic            load_fire;
  logic [3:0]      load_idx;
  logic [1:0]      sm1;
  logic [2:0]      bidx;
  logic [3:0]      half, jj, idx0, idx1;
  logic [2:0]      tw_exp;
  logic [DATA_WIDTH-1:0] twiddle, bf_sum, bf_diff;

  assign load_fire = in_valid && in_ready;

`ifdef NTT_CTRL_BITREV_EN
  assign load_idx = bitrev4(cnt_q);
`else
  assign load_idx = cnt_q;
`endif

  // comp_q = {stage-1, butterfly}; index and twiddle-exponent math uses shifts by stage.
  always_comb begin
    sm1    = comp_q[4:3];
    bidx   = comp_q[2:0];
    half   = 4'd1 << sm1;
    jj     = {1'b0, bidx} & (half - 4'd1);
    idx0   = (({1'b0, bidx} >> sm1) << ({1'b0, sm1} + 3'd1)) | jj;
    idx1   = idx0 + half;
    tw_exp = 3'(jj << (2'd3 - sm1));
    twiddle = TW[tw_exp][DATA_WIDTH-1:0];
  end

  ntt_butterfly #(
    .DATA_WIDTH (DATA_WIDTH),
    .MODULUS    (MODULUS)
  ) u_bfly (
    .u        (bank_q[idx0]),
    .v        (bank_q[idx1]),
    .twiddle  (twiddle),
    .out_sum  (bf_sum),
    .out_diff (bf_diff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      comp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      comp_q  <= comp_d;
    end
  end

  // Coefficient storage is deliberately not reset; an abandoned transform leaves it stale.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      bank_q[load_idx] <= in_data;
    end else if (state_q == ST_COMPUTE) begin
      bank_q[idx0] <= bf_sum;
      bank_q[idx1] <= bf_diff;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    comp_d    = comp_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d   = cnt_q + 4'd1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            comp_d  = '0;
            state_d = ST_COMPUTE;
          end
        end
      end
      ST_COMPUTE: begin
        busy   = 1'b1;
        comp_d = comp_q + 5'd1;
        if (comp_q == 5'd31) begin
          state_d = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_data = (state_q == ST_UNLOAD) ? bank_q[cnt_q] : '0;

endmodule

// File: tb/tb_ntt_iter_ctrl.sv
// Scoreboard bench for ntt_iter_ctrl: works with or without NTT_CTRL_BITREV_EN
// by presenting the input in the order the build expects.
module tb_ntt_iter_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned POW3 [16] = '{1, 3, 9, 10, 13, 5, 15, 11, 16, 14, 8, 7, 4, 12, 2, 6};

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned vin  [16];
  int unsigned vexp [16];
  bit          stall_en = 1'b0;

  always #5 clk = ~clk;

  ntt_iter_ctrl #(
    .N          (16),
    .DATA_WIDTH (DW),
    .MODULUS    (17),
    .ROOT       (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int unsigned brev(input int unsigned k);
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output transfer, checks hold under stall.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    exp_t          e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_data", out_data, prev_data);
          check("stall_hold_valid", out_valid, 1);
        end
        if (out_valid && out_ready) begin
          check("output_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("done_on_transfer", done, e.last);
          end
        end else begin
          check("done_without_transfer", done, 0);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_out_data"}, out_data, 0);
  endtask

  // Loads vin (reordered for the build), then tracks busy/out_valid latency.
  // abort_at != 0 asserts reset at that COMPUTE cycle instead.
  task automatic run_vec(input bit push_exp, input int abort_at);
    int unsigned idx;
    int          busy_n;
    int          first_ov;
    exp_t        e;
    if (push_exp) begin
      for (int k = 0; k < 16; k++) begin
        e.data = DW'(vexp[k]);
        e.last = (k == 15);
        exp_q.push_back(e);
      end
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("in_ready_load", in_ready, 1);
`ifdef NTT_CTRL_BITREV_EN
      idx = k;
`else
      idx = brev(k);
`endif
      in_valid = 1'b1;
      in_data  = DW'(vin[idx]);
      @(posedge clk);
      #1;
    end
    if (stall_en) begin
      in_data = DW'(5);
    end else begin
      in_valid = 1'b0;
    end
    busy_n   = 0;
    first_ov = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (n == 1) check("busy_first_cycle", busy, 1);
      if (in_valid && n <= 32) check("in_ready_blocked", in_ready, 0);
      if (out_valid && first_ov == 0) first_ov = n;
      if (n == 20) in_valid = 1'b0;
      if (abort_at != 0 && n == abort_at) begin
        check("busy_before_abort", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        return;
      end
    end
    check("busy_cycles", busy_n, 32);
    check("out_valid_latency", first_ov, 33);
  endtask

  task automatic wait_drain();
    int unsigned b;
    b = 0;
    while (exp_q.size() != 0 && b < 500) begin
      @(negedge clk);
      b++;
    end
    check("drain_in_time", b < 500, 1);
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
  endtask

  task automatic set_delta0();
    for (int k = 0; k < 16; k++) begin
      vin[k]  = (k == 0) ? 1 : 0;
      vexp[k] = 1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check_reset_outputs("reset");
    #22;
    rst_n = 1'b1;

    set_delta0();
    run_vec(1'b1, 0);
    wait_drain();

    for (int k = 0; k < 16; k++) begin
      vin[k]  = 1;
      vexp[k] = (k == 0) ? 16 : 0;
    end
    run_vec(1'b1, 0);
    wait_drain();

    for (int k = 0; k < 16; k++) begin
      vin[k]  = (k == 1) ? 1 : 0;
      vexp[k] = POW3[k];
    end
    run_vec(1'b1, 0);
    wait_drain();

    stall_en = 1'b1;
    run_vec(1'b1, 0);
    wait_drain();
    stall_en = 1'b0;

    set_delta0();
    run_vec(1'b0, 10);
    #3;
    rst_n = 1'b1;
    run_vec(1'b1, 0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ntt_iter_ctrl.md
NTT_ITER_CTRL -- requirements
Module: ntt_iter_ctrl

Interface
REQ-001 SHALL have parameter N, default 16: transform length; only 16 is supported.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: coefficient width.
REQ-003 SHALL have parameter MODULUS, default 17: prime modulus q.
REQ-004 SHALL have parameter ROOT, default 3: primitive N-th root of unity mod q.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have in_valid / in_ready / in_data[DATA_WIDTH-1:0]: serial coefficient load; a transfer occurs when in_valid && in_ready.
REQ-008 SHALL have out_valid / out_ready / out_data[DATA_WIDTH-1:0]: serial result unload; a transfer occurs when out_valid && out_ready.
REQ-009 SHALL have busy, output, 1 bit: high in the COMPUTE state.
REQ-010 SHALL have done, output, 1 bit: one-cycle pulse on the last output transfer.

Function
REQ-011 SHALL implement FSM states IDLE -> LOAD -> COMPUTE -> UNLOAD -> IDLE.
REQ-012 IDLE: in_ready=1; the first input transfer enters LOAD.
REQ-013 LOAD: in_ready=1; the 16th transfer moves to COMPUTE on the next cycle; input order is a[0] first.
REQ-014 SHALL hold a 16-entry x DATA_WIDTH register bank, with a 4-bit load/unload counter that wraps 15->0.
REQ-015 COMPUTE: SHALL perform exactly one butterfly per cycle, with stage s=1..4 and butterfly b=0..7: 32 cycles total.
REQ-016 Index rules: LEN=2^s, HALF=LEN/2, j=b mod HALF, idx0=(b/HALF)*LEN+j, idx1=idx0+HALF.
REQ-017 Twiddle rule: twiddle=ROOT^(j*N/LEN) mod q.
REQ-018 Butterfly rules: out_sum=(u+w*v) mod q to idx0; out_diff=(u-w*v) mod q to idx1; results written back in the same cycle.
REQ-019 Intermediate products SHALL be at least 2*DATA_WIDTH bits wide; all stored values SHALL be < MODULUS.
REQ-020 UNLOAD: out_valid=1; out_data=bank[cnt] in natural order X[0]..X[15].
REQ-021 Under backpressure (out_ready=0), out_data SHALL be held stable.
REQ-022 in_ready SHALL be 0 in COMPUTE and UNLOAD; in_valid SHALL be ignored there.
REQ-023 Latency: if the last input is accepted at cycle t, out_valid SHALL first rise at t+33 and busy SHALL be high for cycles t+1..t+32.
REQ-024 done SHALL pulse in the same cycle as the 16th output transfer; the FSM returns to IDLE next cycle, with in_ready=1.
REQ-025 A new load SHALL NOT begin in the done cycle.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, all counters 0, and in_ready=1, out_valid=0, busy=0, done=0, out_data=0.
REQ-027 Reset mid-LOAD/COMPUTE/UNLOAD SHALL abandon the transform; the bank contents are don't-care and are not cleared.
REQ-028 Reset release SHALL be effective on the first clk edge after rst_n rises.

Configuration
REQ-029 Macro NTT_CTRL_BITREV_EN, defined: load writes input k to bank[bitrev4(k)], so input and output are both in natural order.
REQ-030 Macro NTT_CTRL_BITREV_EN, undefined: load writes bank[k]; the caller supplies bit-reversed input, and output is still natural order; timing is identical.

Structure
REQ-031 Package ntt_ctrl_pkg SHALL hold the FSM state enum, the bitrev4 function and the twiddle-table function (ROOT^k mod MODULUS, k=0..N/2-1).
REQ-032 SHALL instantiate exactly one sub-module: the existing butterfly (ports u, v, twiddle, out_sum, out_diff; parameters DATA_WIDTH, MODULUS).

Verification
REQ-033 Macro on, input [1,0,...,0] -> outputs all 1, done after 16th output, 33-cycle latency checked.
REQ-034 Macro on, input all 1 -> X[0]=16, X[1..15]=0.
REQ-035 Macro on, input x[1]=1 else 0 -> X[k]=3^k mod 17: 1,3,9,10,13,5,15,11,16,14,8,7,4,12,2,6.
REQ-036 Random out_ready toggling on REQ-035 data -> identical sequence, out_data stable while stalled, in_valid during COMPUTE ignored.
REQ-037 Assert rst_n low at COMPUTE cycle 10 -> outputs at reset values immediately; a fresh REQ-033 run then passes.
REQ-038 Macro off, bit-reversed delta-at-1 input (x[8]=1) -> same outputs as REQ-035.
